// File: rtl/kernel_a_ostream_pack_pkg.sv
// Shared definitions for the kernel_A output-stream packer.
// Holds default geometry, the lane-counter width for the default geometry,
// the output-register state encoding and a lane bit-offset helper.
package kernel_a_ostream_pack_pkg;

    localparam int unsigned STREAMW_DEF = 32;
    localparam int unsigned VECT_DEF    = 8;
    localparam int unsigned CNTW_DEF    = 32;
    localparam int unsigned LANEW       = $clog2(VECT_DEF);

    // Output register occupancy; EMPTY <-> ovalid = 0, FULL <-> ovalid = 1.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1
    } state_e;

    // Bit offset of lane `lane` in a packed word of `w`-bit lanes.
    function automatic int unsigned lane_off(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/kernel_a_ostream_pack_lane_reg.sv
// One lane of the pack register.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset, clears the lane
//   clr_i   synchronous clear (takes priority over load)
//   load_i  synchronous load of d_i
//   d_i     lane data in
//   q_o     lane data out
module kernel_a_ostream_pack_lane_reg
    import kernel_a_ostream_pack_pkg::*;
#(
    parameter int unsigned W = STREAMW_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (clr_i) begin
            q_o <= '0;
        end else if (load_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/kernel_a_ostream_pack.sv
// Packs VECT consecutive accepted STREAMW-bit beats into one wide word.
// A word completes when VECT beats are gathered or a beat carries ilast.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   ivalid/iready       input beat handshake; idata beat, ilast end of stream
//   ovalid/oready       packed word handshake
//   odata, okeep, olast packed word, lane-valid mask, end-of-stream flag
//   words_out           count of packed words accepted downstream (wraps)
module kernel_a_ostream_pack
    import kernel_a_ostream_pack_pkg::*;
#(
    parameter int unsigned STREAMW = STREAMW_DEF,
    parameter int unsigned VECT    = VECT_DEF,
    parameter int unsigned CNTW    = CNTW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ivalid,
    output logic                    iready,
    input  logic [STREAMW-1:0]      idata,
    input  logic                    ilast,
    output logic                    ovalid,
    input  logic                    oready,
    output logic [STREAMW*VECT-1:0] odata,
    output logic [VECT-1:0]         okeep,
    output logic                    olast,
    output logic [CNTW-1:0]         words_out
);

    localparam int unsigned CW = $clog2(VECT);

    state_e state_q, state_d;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [VECT-1:0]         keep_q, keep_d, keep_new;
    logic [STREAMW*VECT-1:0] lane_flat, merged;
    logic [STREAMW*VECT-1:0] odata_q;
    logic [VECT-1:0]         okeep_q;
    logic                    olast_q;
    logic [CNTW-1:0]         words_q;

    logic in_acc, out_acc, complete, word_load;

    assign ovalid    = (state_q == StFull);
    assign iready    = ~ovalid | oready;
    assign in_acc    = ivalid & iready;
    assign out_acc   = ovalid & oready;
    assign complete  = (cnt_q == CW'(VECT - 1)) | ilast;
    assign word_load = in_acc & complete;

    assign odata     = odata_q;
    assign okeep     = okeep_q;
    assign olast     = olast_q;
    assign words_out = words_q;

    // The completing beat bypasses the lanes and goes straight into the output
    // register, so the lanes only ever hold beats of an unfinished word.
    for (genvar k = 0; k < VECT; k++) begin : g_lane
        kernel_a_ostream_pack_lane_reg #(
            .W (STREAMW)
        ) u_lane (
            .clk_i  (clk),
            .rst_ni (rst),
            .clr_i  (word_load),
            .load_i (in_acc & ~complete & (cnt_q == CW'(k))),
            .d_i    (idata),
            .q_o    (lane_flat[lane_off(k, STREAMW) +: STREAMW])
        );
    end

    // Lanes above cnt are still cleared, so partial words read 0 there.
    always_comb begin
        merged = lane_flat;
        for (int unsigned k = 0; k < VECT; k++) begin
            if (cnt_q == CW'(k)) begin
                merged[lane_off(k, STREAMW) +: STREAMW] = idata;
            end
        end
        keep_new         = keep_q;
        keep_new[cnt_q]  = 1'b1;
    end

    always_comb begin
        cnt_d  = cnt_q;
        keep_d = keep_q;
        if (in_acc) begin
            if (complete) begin
                cnt_d  = '0;
                keep_d = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                keep_d = keep_new;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (word_load) state_d = StFull;
            StFull:  if (out_acc && !word_load) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
            cnt_q   <= '0;
            keep_q  <= '0;
            odata_q <= '0;
            okeep_q <= '0;
            olast_q <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            keep_q  <= keep_d;
            if (word_load) begin
                odata_q <= merged;
                okeep_q <= keep_new;
                olast_q <= ilast;
            end
            if (out_acc) begin
                words_q <= words_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kernel_a_ostream_pack.sv
module tb_kernel_a_ostream_pack;

    localparam int unsigned W  = 32;
    localparam int unsigned V  = 8;
    localparam int unsigned CN = 32;
    localparam int unsigned DW = W * V;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ivalid = 1'b0;
    logic          iready;
    logic [W-1:0]  idata = '0;
    logic          ilast = 1'b0;
    logic          ovalid;
    logic          oready = 1'b0;
    logic [DW-1:0] odata;
    logic [V-1:0]  okeep;
    logic          olast;
    logic [CN-1:0] words_out;

    kernel_a_ostream_pack #(
        .STREAMW (W),
        .VECT    (V),
        .CNTW    (CN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ivalid    (ivalid),
        .iready    (iready),
        .idata     (idata),
        .ilast     (ilast),
        .ovalid    (ovalid),
        .oready    (oready),
        .odata     (odata),
        .okeep     (okeep),
        .olast     (olast),
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [V-1:0]  k;
        logic          l;
    } word_t;

    int n_cmp = 0;
    int n_err = 0;

    word_t        exp_q[$];   // words the model says must appear, in order
    word_t        acc_log[$]; // words seen accepted downstream
    logic [W-1:0] part[$];    // beats of the word being gathered
    int           exp_words = 0;
    int           n_olast   = 0;
    bit           prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic [V-1:0]  prev_k;
    logic          prev_l;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model and per-cycle compare, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            part.delete();
            exp_words  = 0;
            n_olast    = 0;
            prev_stall = 1'b0;
        end else begin
            chk("ovalid_vs_model", DW'(ovalid), DW'(exp_q.size() != 0));
            chk("iready_rule", DW'(iready), DW'(!ovalid || oready));
            chk("words_out", DW'(words_out), DW'(exp_words));
            if (prev_stall) begin
                chk("stall_ovalid", DW'(ovalid), DW'(1));
                chk("stall_odata", odata, prev_d);
                chk("stall_okeep", DW'(okeep), DW'(prev_k));
                chk("stall_olast", DW'(olast), DW'(prev_l));
            end
            if (ovalid && oready && exp_q.size() != 0) begin
                word_t w;
                w = exp_q.pop_front();
                chk("odata", odata, w.d);
                chk("okeep", DW'(okeep), DW'(w.k));
                chk("olast", DW'(olast), DW'(w.l));
                acc_log.push_back('{odata, okeep, olast});
                exp_words++;
                if (w.l) n_olast++;
            end
            prev_stall = ovalid && !oready;
            prev_d     = odata;
            prev_k     = okeep;
            prev_l     = olast;
            if (ivalid && iready) begin
                part.push_back(idata);
                if (part.size() == V || ilast) begin
                    word_t w;
                    w.d = '0;
                    w.k = '0;
                    w.l = ilast;
                    for (int i = 0; i < part.size(); i++) begin
                        w.d[i*W +: W] = part[i];
                        w.k[i]        = 1'b1;
                    end
                    exp_q.push_back(w);
                    part.delete();
                end
            end
        end
    end

    // Present a beat and hold it until it is accepted; leaves ivalid high.
    task automatic send_beat(input logic [W-1:0] d, input logic l);
        ivalid = 1'b1;
        idata  = d;
        ilast  = l;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (iready) break;
            if (t > 300) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat_timeout: got iready=0 for %0d cycles expected acceptance", t);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ivalid = 1'b0;
        ilast  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        oready = 1'b1;
        ivalid = 1'b0;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ovalid) break;
            if (t > 300) begin
                n_cmp++;
                n_err++;
                $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_last(input string name, input logic [DW-1:0] d, input logic [V-1:0] k,
                            input logic l);
        if (acc_log.size() == 0) begin
            chk({name, "_present"}, DW'(0), DW'(1));
        end else begin
            chk({name, "_data"}, acc_log[acc_log.size()-1].d, d);
            chk({name, "_keep"}, DW'(acc_log[acc_log.size()-1].k), DW'(k));
            chk({name, "_last"}, DW'(acc_log[acc_log.size()-1].l), DW'(l));
        end
    endtask

    initial begin
        int base;
        bit done;

        // Reset values
        #2;
        chk("rst_ovalid", DW'(ovalid), DW'(0));
        chk("rst_iready", DW'(iready), DW'(1));
        chk("rst_words", DW'(words_out), DW'(0));
        chk("rst_odata", odata, '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // Full word with ilast on lane 7
        oready = 1'b1;
        for (int i = 1; i <= 8; i++) send_beat(W'(i), i == 8);
        idle(3);
        chk_last("t1", {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, 8'hFF, 1'b1);
        chk("t1_words", DW'(words_out), DW'(1));

        // Two words back to back while downstream stalls
        oready = 1'b0;
        base   = acc_log.size();
        fork
            for (int i = 16; i < 32; i++) send_beat(W'(i), 1'b0);
            begin
                repeat (15) @(posedge clk);
                @(negedge clk);
                chk("t2_stall_iready", DW'(iready), DW'(0));
                chk("t2_stall_ovalid", DW'(ovalid), DW'(1));
                @(posedge clk);
                #1;
                oready = 1'b1;
            end
        join
        drain();
        chk("t2_count", DW'(acc_log.size() - base), DW'(2));
        if (acc_log.size() >= base + 2) begin
            chk("t2_w0", acc_log[base].d,
                {32'h17, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11, 32'h10});
            chk("t2_w1", acc_log[base+1].d,
                {32'h1F, 32'h1E, 32'h1D, 32'h1C, 32'h1B, 32'h1A, 32'h19, 32'h18});
        end
        chk("t2_words", DW'(words_out), DW'(3));

        // Three-beat partial word
        send_beat(32'hA, 1'b0);
        send_beat(32'hB, 1'b0);
        send_beat(32'hC, 1'b1);
        idle(3);
        chk_last("t3", {160'h0, 32'hC, 32'hB, 32'hA}, 8'h07, 1'b1);

        // ilast on lane 0
        send_beat(32'h55, 1'b1);
        idle(3);
        chk_last("t4", {224'h0, 32'h55}, 8'h01, 1'b1);

        // Asynchronous reset mid-word
        for (int i = 0; i < 5; i++) send_beat(32'hE0 + W'(i), 1'b0);
        ivalid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_ovalid", DW'(ovalid), DW'(0));
        chk("ar_odata", odata, '0);
        chk("ar_okeep", DW'(okeep), DW'(0));
        chk("ar_olast", DW'(olast), DW'(0));
        chk("ar_words", DW'(words_out), DW'(0));
        chk("ar_iready", DW'(iready), DW'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++) send_beat(32'h21 + W'(i), 1'b0);
        idle(3);
        chk_last("ar_clean", {32'h28, 32'h27, 32'h26, 32'h25, 32'h24, 32'h23, 32'h22, 32'h21},
                 8'hFF, 1'b0);
        chk("ar_words_after", DW'(words_out), DW'(1));

        // Randomised traffic from a fresh reset
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    while ($urandom_range(0, 1) == 0) begin
                        ivalid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send_beat($urandom, (i % 13 == 12) || (i == 999));
                end
                ivalid = 1'b0;
                done   = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    oready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        drain();
        idle(2);
        chk("rand_leftover", DW'(part.size()), DW'(0));
        chk("rand_words", DW'(words_out), DW'(154));
        chk("rand_olast_words", DW'(n_olast), DW'(77));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
